mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu_pkg.sv | 32 +++
 rtl/mdu_if.sv | 30 +++
 rtl/mdu_iter_core.sv | 88 ++++++++
 rtl/mdu.sv | 185 ++++++++++++++++++
 tb/tb_mdu.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared MDU types and constants: FSM states, one-hot op indices, HI/LO bus layout.
// Used by mdu, mdu_iter_core and the mdu_if interface.
package mdu_pkg;

  localparam int HILO_BUS_WD = 66;
  localparam int OP_WD       = 6;

  localparam int OP_DIV   = 0;
  localparam int OP_DIVU  = 1;
  localparam int OP_MULT  = 2;
  localparam int OP_MULTU = 3;
  localparam int OP_MTHI  = 4;
  localparam int OP_MTLO  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mdu_state_e;

  typedef struct packed {
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_data;
    logic [31:0] lo_data;
  } hilo_bus_t;

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/mdu_if.sv
// EX-stage <-> MDU signal bundle: operation/operands in, stall request and HI/LO write bus out.
// The pipeline side uses modport master, the MDU uses modport slave.
interface mdu_if;
  import mdu_pkg::*;

  logic                   flush;
  logic                   ex_advance;
  logic                   op_div;
  logic                   op_divu;
  logic                   op_mult;
  logic                   op_multu;
  logic                   op_mthi;
  logic                   op_mtlo;
  logic [31:0]            src_a;
  logic [31:0]            src_b;
  logic                   stallreq_ex;
  logic [HILO_BUS_WD-1:0] hilo_bus;

  modport master (
    output flush, ex_advance, op_div, op_divu, op_mult, op_multu, op_mthi, op_mtlo,
           src_a, src_b,
    input  stallreq_ex, hilo_bus
  );

  modport slave (
    input  flush, ex_advance, op_div, op_divu, op_mult, op_multu, op_mthi, op_mtlo,
           src_a, src_b,
    output stallreq_ex, hilo_bus
  );
endinterface

// File: rtl/mdu_iter_core.sv
// One-bit-per-cycle unsigned datapath: restoring divide, plus shift-add multiply when
// MDU_MUL_ITER_EN is defined. acc ends as remainder/product-high, sh as quotient/product-low.
module mdu_iter_core (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
`ifdef MDU_MUL_ITER_EN
  input  logic        is_mul,
`endif
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic [31:0] acc,
  output logic [31:0] sh
);

  logic [31:0] acc_q, acc_d;
  logic [31:0] sh_q, sh_d;
  logic [31:0] opnd_q, opnd_d;
  logic [32:0] trial;
  logic [31:0] div_acc, div_sh;
`ifdef MDU_MUL_ITER_EN
  logic        mul_q, mul_d;
  logic [32:0] sum;
`endif

  always_comb begin
    acc_d  = acc_q;
    sh_d   = sh_q;
    opnd_d = opnd_q;
    // A borrow out of bit 32 means the shifted remainder is below the divisor.
    trial  = {acc_q, sh_q[31]} - {1'b0, opnd_q};
    if (!trial[32]) begin
      div_acc = trial[31:0];
      div_sh  = {sh_q[30:0], 1'b1};
    end else begin
      div_acc = {acc_q[30:0], sh_q[31]};
      div_sh  = {sh_q[30:0], 1'b0};
    end
`ifdef MDU_MUL_ITER_EN
    mul_d = mul_q;
    sum   = {1'b0, acc_q} + {1'b0, (sh_q[0] ? opnd_q : 32'd0)};
`endif
    if (load) begin
      acc_d  = '0;
      sh_d   = a_in;
      opnd_d = b_in;
`ifdef MDU_MUL_ITER_EN
      mul_d  = is_mul;
`endif
    end else if (step) begin
`ifdef MDU_MUL_ITER_EN
      if (mul_q) begin
        acc_d = sum[32:1];
        sh_d  = {sum[0], sh_q[31:1]};
      end else begin
        acc_d = div_acc;
        sh_d  = div_sh;
      end
`else
      acc_d = div_acc;
      sh_d  = div_sh;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      sh_q   <= '0;
      opnd_q <= '0;
`ifdef MDU_MUL_ITER_EN
      mul_q  <= 1'b0;
`endif
    end else begin
      acc_q  <= acc_d;
      sh_q   <= sh_d;
      opnd_q <= opnd_d;
`ifdef MDU_MUL_ITER_EN
      mul_q  <= mul_d;
`endif
    end
  end

  assign acc = acc_q;
  assign sh  = sh_q;

endmodule

// File: rtl/mdu.sv
// EX-stage multiply/divide unit: IDLE/BUSY/DONE control, sign handling, HI/LO bus packing.
// Define MDU_MUL_ITER_EN to run mult/multu iteratively; otherwise they complete in the start cycle.
module mdu import mdu_pkg::*; (
  input logic  clk,
  input logic  rst,
  mdu_if.slave ex
);

  mdu_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        consumed_q, consumed_d;
  logic        neg_q, neg_d;
  logic        rem_neg_q, rem_neg_d;
  logic        div0_q, div0_d;
`ifdef MDU_MUL_ITER_EN
  logic        mul_q, mul_d;
  logic [63:0] prod_mag;
`else
  logic [63:0] mul_a_ext, mul_b_ext, mul_prod;
`endif

  logic [OP_WD-1:0] ops;
  logic        is_div, is_mul, is_signed, sgn_a, sgn_b, b_zero, accept;
  logic [31:0] a_mag, b_mag, core_a, core_hi, core_lo;
  logic        core_load, core_step, stall;
  hilo_bus_t   bus;

  assign ops = {ex.op_mtlo, ex.op_mthi, ex.op_multu, ex.op_mult, ex.op_divu, ex.op_div};

  assign is_div    = ops[OP_DIV]  | ops[OP_DIVU];
  assign is_mul    = ops[OP_MULT] | ops[OP_MULTU];
  assign is_signed = ops[OP_DIV]  | ops[OP_MULT];
  assign sgn_a     = is_signed & ex.src_a[31];
  assign sgn_b     = is_signed & ex.src_b[31];
  assign a_mag     = neg_if(ex.src_a, sgn_a);
  assign b_mag     = neg_if(ex.src_b, sgn_b);
  assign b_zero    = (ex.src_b == 32'd0);
  // A zero divisor never steps, so the raw dividend parked in the core becomes HI.
  assign core_a    = (is_div && b_zero) ? ex.src_a : a_mag;
  assign accept    = (state_q == IDLE) && (is_div || is_mul) && !consumed_q;

`ifdef MDU_MUL_ITER_EN
  assign prod_mag  = {core_hi, core_lo};
`else
  assign mul_a_ext = {{32{sgn_a}}, ex.src_a};
  assign mul_b_ext = {{32{sgn_b}}, ex.src_b};
  assign mul_prod  = mul_a_ext * mul_b_ext;
`endif

  mdu_iter_core u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (core_load),
    .step   (core_step),
`ifdef MDU_MUL_ITER_EN
    .is_mul (is_mul),
`endif
    .a_in   (core_a),
    .b_in   (b_mag),
    .acc    (core_hi),
    .sh     (core_lo)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    consumed_d = consumed_q;
    neg_d      = neg_q;
    rem_neg_d  = rem_neg_q;
    div0_d     = div0_q;
`ifdef MDU_MUL_ITER_EN
    mul_d      = mul_q;
`endif
    core_load  = 1'b0;
    core_step  = 1'b0;
    stall      = 1'b0;
    bus        = '0;

    case (state_q)
      IDLE: begin
        if (accept && is_div) begin
          core_load = 1'b1;
          stall     = 1'b1;
          cnt_d     = '0;
          neg_d     = sgn_a ^ sgn_b;
          rem_neg_d = sgn_a;
          div0_d    = b_zero;
`ifdef MDU_MUL_ITER_EN
          mul_d     = 1'b0;
`endif
          state_d   = b_zero ? DONE : BUSY;
        end else if (accept) begin
`ifdef MDU_MUL_ITER_EN
          core_load = 1'b1;
          stall     = 1'b1;
          cnt_d     = '0;
          neg_d     = sgn_a ^ sgn_b;
          div0_d    = 1'b0;
          mul_d     = 1'b1;
          state_d   = BUSY;
`else
          bus.hi_we   = 1'b1;
          bus.lo_we   = 1'b1;
          bus.hi_data = mul_prod[63:32];
          bus.lo_data = mul_prod[31:0];
          consumed_d  = 1'b1;
`endif
        end
        if (ex.op_mthi) begin
          bus.hi_we   = 1'b1;
          bus.hi_data = ex.src_a;
        end
        if (ex.op_mtlo) begin
          bus.lo_we   = 1'b1;
          bus.lo_data = ex.src_a;
        end
      end
      BUSY: begin
        stall     = 1'b1;
        core_step = 1'b1;
        cnt_d     = cnt_q + 6'd1;
        if (cnt_q == 6'd31) state_d = DONE;
      end
      DONE: begin
        bus.hi_we = 1'b1;
        bus.lo_we = 1'b1;
`ifdef MDU_MUL_ITER_EN
        if (mul_q) begin
          {bus.hi_data, bus.lo_data} = neg_q ? (64'd0 - prod_mag) : prod_mag;
        end else
`endif
        if (div0_q) begin
          bus.hi_data = core_lo;
          bus.lo_data = 32'hFFFF_FFFF;
        end else begin
          bus.hi_data = neg_if(core_hi, rem_neg_q);
          bus.lo_data = neg_if(core_lo, neg_q);
        end
        consumed_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The instruction that set the flag leaves EX on advance.
    if (ex.ex_advance) consumed_d = 1'b0;

    if (ex.flush) begin
      state_d    = IDLE;
      consumed_d = 1'b0;
      core_load  = 1'b0;
      core_step  = 1'b0;
      stall      = 1'b0;
      bus        = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      consumed_q <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      div0_q     <= 1'b0;
`ifdef MDU_MUL_ITER_EN
      mul_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      consumed_q <= consumed_d;
      neg_q      <= neg_d;
      rem_neg_q  <= rem_neg_d;
      div0_q     <= div0_d;
`ifdef MDU_MUL_ITER_EN
      mul_q      <= mul_d;
`endif
    end
  end

  assign ex.stallreq_ex = stall & ~rst;
  assign ex.hilo_bus    = rst ? '0 : bus;

endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: a per-cycle expectation table filled from an arithmetic model,
// checked against stallreq_ex and hilo_bus on every falling edge.
module tb_mdu;
  import mdu_pkg::*;

  localparam int MAXC    = 2048;
  localparam int K_DIV   = 0;
  localparam int K_DIVU  = 1;
  localparam int K_MULT  = 2;
  localparam int K_MULTU = 3;
  localparam int K_MTHI  = 4;
  localparam int K_MTLO  = 5;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   chk_on = 1'b0;

  logic        exp_stall [MAXC];
  logic        exp_hwe   [MAXC];
  logic        exp_lwe   [MAXC];
  logic        exp_zero  [MAXC];
  logic [31:0] exp_hi    [MAXC];
  logic [31:0] exp_lo    [MAXC];

  mdu_if     ex();
  hilo_bus_t obs;

  mdu dut (.clk(clk), .rst(rst), .ex(ex));

  assign obs = ex.hilo_bus;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // {hi, lo} the architecture must write for one operation.
  function automatic logic [63:0] model(input int kind, input logic [31:0] a, input logic [31:0] b);
    int     sa, sb;
    longint pa, pb;
    sa = $signed(a);
    sb = $signed(b);
    pa = sa;
    pb = sb;
    case (kind)
      K_DIV: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(sa % sb), 32'(sa / sb)};
      end
      K_DIVU:  return (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      K_MULT:  return 64'(pa * pb);
      K_MULTU: return {32'd0, a} * {32'd0, b};
      default: return {a, a};
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_on && cyc < MAXC) begin
      check("stallreq_ex", 66'(ex.stallreq_ex), 66'(exp_stall[cyc]));
      check("hi_we", 66'(obs.hi_we), 66'(exp_hwe[cyc]));
      check("lo_we", 66'(obs.lo_we), 66'(exp_lwe[cyc]));
      if (exp_hwe[cyc]) check("hi_data", 66'(obs.hi_data), 66'(exp_hi[cyc]));
      if (exp_lwe[cyc]) check("lo_data", 66'(obs.lo_data), 66'(exp_lo[cyc]));
      if (exp_zero[cyc]) check("hilo_bus_rst", ex.hilo_bus, 66'd0);
    end
  end

  task automatic drive_op(input int kind, input logic [31:0] a, input logic [31:0] b);
    ex.op_div   = (kind == K_DIV);
    ex.op_divu  = (kind == K_DIVU);
    ex.op_mult  = (kind == K_MULT);
    ex.op_multu = (kind == K_MULTU);
    ex.op_mthi  = (kind == K_MTHI);
    ex.op_mtlo  = (kind == K_MTLO);
    ex.src_a    = a;
    ex.src_b    = b;
  endtask

  task automatic clear_op();
    drive_op(-1, 32'd0, 32'd0);
  endtask

  // Stall covers S..S+lat-1, the single write lands at S+lat.
  task automatic sched(input int kind, input logic [31:0] a, input logic [31:0] b,
                       input int s, output int lat);
    logic [63:0] r;
    r = model(kind, a, b);
    if (kind == K_MTHI || kind == K_MTLO) lat = 0;
    else if (kind == K_DIV || kind == K_DIVU) lat = (b == 32'd0) ? 1 : 33;
    else begin
`ifdef MDU_MUL_ITER_EN
      lat = 33;
`else
      lat = 0;
`endif
    end
    for (int c = s; c < s + lat; c++) exp_stall[c] = 1'b1;
    exp_hwe[s + lat] = (kind != K_MTLO);
    exp_lwe[s + lat] = (kind != K_MTHI);
    exp_hi[s + lat]  = r[63:32];
    exp_lo[s + lat]  = r[31:0];
  endtask

  task automatic pin(input int kind, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] lit_hi, input logic [31:0] lit_lo);
    logic [63:0] r;
    r = model(kind, a, b);
    check("model_hi", 66'(r[63:32]), 66'(lit_hi));
    check("model_lo", 66'(r[31:0]), 66'(lit_lo));
  endtask

  task automatic run(input int kind, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] lit_hi, input logic [31:0] lit_lo);
    int s, lat;
    pin(kind, a, b, lit_hi, lit_lo);
    @(posedge clk); #1;
    drive_op(kind, a, b);
    ex.ex_advance = 1'b0;
    s = cyc;
    sched(kind, a, b, s, lat);
    repeat (lat) begin @(posedge clk); #1; end
    ex.ex_advance = 1'b1;
    @(posedge clk); #1;
    clear_op();
    ex.ex_advance = 1'b0;
  endtask

  initial begin
    int s, lat;
    for (int c = 0; c < MAXC; c++) begin
      exp_stall[c] = 1'b0;
      exp_hwe[c]   = 1'b0;
      exp_lwe[c]   = 1'b0;
      exp_zero[c]  = 1'b0;
      exp_hi[c]    = '0;
      exp_lo[c]    = '0;
    end
    ex.flush      = 1'b0;
    ex.ex_advance = 1'b0;
    clear_op();
    rst    = 1'b1;
    chk_on = 1'b1;
    repeat (3) begin
      exp_zero[cyc] = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b0;

    run(K_DIVU,  32'd100,         32'd7,           32'd2,           32'd14);
    run(K_DIV,   32'hFFFF_FFF9,   32'd2,           32'hFFFF_FFFF,   32'hFFFF_FFFD);
    run(K_DIV,   32'h8000_0000,   32'hFFFF_FFFF,   32'd0,           32'h8000_0000);
    run(K_DIVU,  32'd5,           32'd0,           32'd5,           32'hFFFF_FFFF);
    run(K_DIV,   32'hFFFF_FFF7,   32'd0,           32'hFFFF_FFF7,   32'hFFFF_FFFF);
    run(K_DIVU,  32'hFFFF_FFFF,   32'd10,          32'd5,           32'h1999_9999);
    run(K_DIV,   32'd7,           32'hFFFF_FFFE,   32'd1,           32'hFFFF_FFFD);
    run(K_MULTU, 32'hFFFF_FFFF,   32'd2,           32'd1,           32'hFFFF_FFFE);
    run(K_MULT,  32'hFFFF_FFFD,   32'd5,           32'hFFFF_FFFF,   32'hFFFF_FFF1);
    run(K_MTHI,  32'h1234,        32'd0,           32'h1234,        32'h1234);
    run(K_MTLO,  32'hABCD,        32'd0,           32'hABCD,        32'hABCD);

    // Divide held in EX past its write-back: must not restart until EX advances.
    pin(K_DIV, 32'd20, 32'd3, 32'd2, 32'd6);
    pin(K_DIV, 32'd9,  32'd4, 32'd1, 32'd2);
    @(posedge clk); #1;
    drive_op(K_DIV, 32'd20, 32'd3);
    s = cyc;
    sched(K_DIV, 32'd20, 32'd3, s, lat);
    repeat (37) begin @(posedge clk); #1; end
    ex.ex_advance = 1'b1;
    drive_op(K_DIV, 32'd9, 32'd4);
    @(posedge clk); #1;
    ex.ex_advance = 1'b0;
    sched(K_DIV, 32'd9, 32'd4, cyc, lat);
    repeat (lat) begin @(posedge clk); #1; end
    ex.ex_advance = 1'b1;
    @(posedge clk); #1;
    clear_op();
    ex.ex_advance = 1'b0;

    // Flush ten cycles into a divide: stall drops that cycle and no write ever follows.
    @(posedge clk); #1;
    drive_op(K_DIV, 32'd1000, 32'd3);
    s = cyc;
    for (int c = s; c < s + 10; c++) exp_stall[c] = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    ex.flush = 1'b1;
    @(posedge clk); #1;
    ex.flush = 1'b0;
    clear_op();
    repeat (30) begin @(posedge clk); #1; end

    // Reset five cycles into a divide.
    @(posedge clk); #1;
    drive_op(K_DIVU, 32'd1000, 32'd7);
    s = cyc;
    for (int c = s; c < s + 5; c++) exp_stall[c] = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1;
    clear_op();
    exp_zero[cyc] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (35) begin @(posedge clk); #1; end

    // Flush suppresses an mthi write in the same cycle.
    drive_op(K_MTHI, 32'h55, 32'd0);
    ex.flush = 1'b1;
    @(posedge clk); #1;
    ex.flush = 1'b0;
    clear_op();
    repeat (3) begin @(posedge clk); #1; end

    @(negedge clk); #1;
    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
